// File: rtl/board_cfg_sequencer.sv
// board_cfg_sequencer: power-up, clock-chip config, PLL lock qualification and ADC bring-up with bounded retries
module board_cfg_sequencer #(
   parameter int unsigned PWRUP_WAIT     = 1000,
   parameter int unsigned CFG_TIMEOUT    = 50000,
   parameter int unsigned LOCK_TIMEOUT   = 100000,
   parameter int unsigned LOCK_STABLE    = 256,
   parameter int unsigned ADC_RST_CYCLES = 64,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       clk_cfg_en,
   input  logic       clk_cfg_finish_n,
   input  logic       pll_lock,
   output logic       adc_rst,
   output logic       adc_cfg_req,
   input  logic       adc_cfg_ack,
   output logic       board_ready,
   output logic       error,
   output logic [1:0] retry_cnt,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_PWRUP       = 4'd1,
      S_CLK_CFG     = 4'd2,
      S_CLK_WAIT    = 4'd3,
      S_LOCK_WAIT   = 4'd4,
      S_LOCK_STABLE = 4'd5,
      S_ADC_RST     = 4'd6,
      S_ADC_CFG     = 4'd7,
      S_READY       = 4'd8,
      S_FAIL        = 4'd9
   } state_t;
   state_t      cur, nxt;
   logic [1:0]  retry_nxt;
   logic [1:0]  sync;
   logic [31:0] timer;
   logic [31:0] dwell;
   logic        lock_s, retry;
   // dwell counts the current cycle, so a limit of N means exactly N cycles in the state
   assign lock_s      = sync[1];
   assign dwell       = timer + 32'd1;
   assign state       = cur;
   assign clk_cfg_en  = cur inside {S_CLK_WAIT, S_LOCK_WAIT, S_LOCK_STABLE, S_ADC_RST, S_ADC_CFG, S_READY};
   assign adc_rst     = cur == S_ADC_RST;
   assign adc_cfg_req = cur == S_ADC_CFG;
   assign board_ready = cur == S_READY;
   assign error       = cur == S_FAIL;
   // two-flop synchronizer for the asynchronous PLL lock
   always_ff @(posedge clk or posedge rst)
      if (rst) sync <= '0;
      else     sync <= {sync[0], pll_lock};
   // state, retry counter and the shared timer, which restarts on every state change
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cur       <= S_IDLE;
         retry_cnt <= '0;
         timer     <= '0;
      end else begin
         cur       <= nxt;
         retry_cnt <= retry_nxt;
         timer     <= (nxt != cur) ? '0 : timer + 32'd1;
      end
   // next-state decode; any retry request is resolved against the retry budget last
   always_comb begin
      nxt       = cur;
      retry     = 1'b0;
      retry_nxt = retry_cnt;
      case (cur)
         S_IDLE, S_FAIL: if (start) begin
            nxt       = S_PWRUP;
            retry_nxt = '0;
         end
         S_PWRUP:       if (dwell == PWRUP_WAIT) nxt = S_CLK_CFG;
         S_CLK_CFG:     nxt = S_CLK_WAIT;
         S_CLK_WAIT:    if (!clk_cfg_finish_n) nxt = S_LOCK_WAIT;
                        else if (dwell == CFG_TIMEOUT) retry = 1'b1;
         S_LOCK_WAIT:   if (lock_s) nxt = S_LOCK_STABLE;
                        else if (dwell == LOCK_TIMEOUT) retry = 1'b1;
         S_LOCK_STABLE: if (!lock_s) nxt = S_LOCK_WAIT;
                        else if (dwell == LOCK_STABLE) nxt = S_ADC_RST;
         S_ADC_RST:     if (!lock_s) retry = 1'b1;
                        else if (dwell == ADC_RST_CYCLES) nxt = S_ADC_CFG;
         S_ADC_CFG:     if (!lock_s) retry = 1'b1;
                        else if (adc_cfg_ack) nxt = S_READY;
         S_READY:       if (!lock_s) retry = 1'b1;
         default:       nxt = S_IDLE;
      endcase
      if (retry) begin
         if (32'(retry_cnt) < MAX_RETRY) begin
            retry_nxt = retry_cnt + 2'd1;
            nxt       = S_CLK_CFG;
         end else begin
            nxt = S_FAIL;
         end
      end
   end
endmodule

// File: tb/tb_board_cfg_sequencer.sv
// tb_board_cfg_sequencer: directed scenarios plus random traffic against a dwell-based reference model
module tb_board_cfg_sequencer;
   localparam int PW = 10, CT = 50, LT = 40, LS = 8, AR = 4, MR = 3;
   logic       clk, rst, start, clk_cfg_en, clk_cfg_finish_n, pll_lock;
   logic       adc_rst, adc_cfg_req, adc_cfg_ack, board_ready, error;
   logic [1:0] retry_cnt;
   logic [3:0] state;
   int  checks = 0, errors = 0;
   int  m_st, m_t, m_rc;
   bit  lq[$];
   int  mode, bias, n_adc, n_s5, n_cfg, last_st, n;
   int  vis[$];
   bit  kick, ack_en, glitched, coin_done, drop;
   board_cfg_sequencer #(
      .PWRUP_WAIT(PW), .CFG_TIMEOUT(CT), .LOCK_TIMEOUT(LT),
      .LOCK_STABLE(LS), .ADC_RST_CYCLES(AR), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .clk_cfg_en(clk_cfg_en),
      .clk_cfg_finish_n(clk_cfg_finish_n), .pll_lock(pll_lock), .adc_rst(adc_rst),
      .adc_cfg_req(adc_cfg_req), .adc_cfg_ack(adc_cfg_ack), .board_ready(board_ready),
      .error(error), .retry_cnt(retry_cnt), .state(state)
   );
   // free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   task automatic check_outputs();
      check("state", 32'(state), 32'(m_st));
      check("clk_cfg_en", 32'(clk_cfg_en), 32'(m_st >= 3 && m_st <= 8));
      check("adc_rst", 32'(adc_rst), 32'(m_st == 6));
      check("adc_cfg_req", 32'(adc_cfg_req), 32'(m_st == 7));
      check("board_ready", 32'(board_ready), 32'(m_st == 8));
      check("error", 32'(error), 32'(m_st == 9));
      check("retry_cnt", 32'(retry_cnt), 32'(m_rc));
   endtask
   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_st = 0; m_t = 0; m_rc = 0;
      lq.delete();
      check_outputs();
      @(negedge clk);
      rst = 1'b0;
      last_st = 0;
   endtask
   task automatic cyc();
      logic pl, fin, ack, lk, st;
      int d, nx;
      bit rty;
      pl  = 1'b1;
      st  = kick;
      kick = 1'b0;
      ack = 1'b0;
      fin = !(m_st == 3 && m_t >= 19);
      case (mode)
         1: pl = 1'b0;
         2: begin
            st  = $urandom_range(15, 0) == 0;
            fin = $urandom_range(7, 0) != 0;
            pl  = $urandom_range(bias - 1, 0) != 0;
            ack = $urandom_range(5, 0) == 0;
         end
         3: if (m_st == 5 && m_t == 4 && !glitched) begin
            pl = 1'b0;
            glitched = 1'b1;
         end
         4: if (m_st == 7 && !coin_done) begin
            pl = 1'b0;
            if (m_t == 2) begin
               ack = 1'b1;
               coin_done = 1'b1;
            end
         end
         5: pl = !drop;
         default: ;
      endcase
      if (mode != 2 && ack_en && m_st == 7 && m_t == 3) ack = 1'b1;
      start = st; pll_lock = pl; clk_cfg_finish_n = fin; adc_cfg_ack = ack;
      @(posedge clk);
      lq.push_back(pl);
      if (lq.size() > 3) void'(lq.pop_front());
      lk = (lq.size() == 3) ? lq[0] : 1'b0;
      d = m_t + 1; nx = m_st; rty = 0;
      case (m_st)
         0, 9: if (st) begin nx = 1; m_rc = 0; end
         1: if (d == PW) nx = 2;
         2: nx = 3;
         3: if (!fin) nx = 4; else if (d == CT) rty = 1;
         4: if (lk) nx = 5; else if (d == LT) rty = 1;
         5: if (!lk) nx = 4; else if (d == LS) nx = 6;
         6: if (!lk) rty = 1; else if (d == AR) nx = 7;
         7: if (!lk) rty = 1; else if (ack) nx = 8;
         8: if (!lk) rty = 1;
         default: nx = 0;
      endcase
      if (rty) begin
         if (m_rc < MR) begin m_rc++; nx = 2; end
         else nx = 9;
      end
      m_t = (nx == m_st) ? m_t + 1 : 0;
      m_st = nx;
      #1;
      check_outputs();
      if (state == 4'd6) n_adc++;
      if (state == 4'd5) n_s5++;
      if (state == 4'd2 && !clk_cfg_en) n_cfg++;
      if (int'(state) != last_st) begin
         vis.push_back(int'(state));
         last_st = int'(state);
      end
      @(negedge clk);
   endtask
   task automatic run_until(input int tgt, input int budget, input string tag);
      for (int i = 0; i < budget && m_st != tgt; i++) cyc();
      check(tag, 32'(state), tgt);
   endtask
   // scenario sequence followed by randomized traffic
   initial begin
      rst = 1'b1; start = 1'b0; clk_cfg_finish_n = 1'b1; pll_lock = 1'b0; adc_cfg_ack = 1'b0;
      mode = 0; bias = 32; kick = 0; ack_en = 1; glitched = 0; coin_done = 0; drop = 0;
      n_adc = 0; n_s5 = 0; n_cfg = 0; last_st = 0;
      @(negedge clk);
      do_reset();
      vis.delete(); n_adc = 0; kick = 1;
      run_until(8, 200, "nominal_ready");
      check("nominal_adc_rst_len", n_adc, AR);
      check("nominal_path_len", vis.size(), 8);
      foreach (vis[i]) check("nominal_path", vis[i], i + 1);
      check("nominal_retry", 32'(retry_cnt), 0);
      repeat (3) cyc();
      check("nominal_hold_ready", 32'(board_ready), 1);
      do_reset();
      mode = 3; glitched = 0; n_s5 = 0; kick = 1;
      run_until(8, 300, "glitch_ready");
      check("glitch_stable_cycles", n_s5, 15);
      check("glitch_retry", 32'(retry_cnt), 0);
      do_reset();
      mode = 4; coin_done = 0; kick = 1;
      run_until(7, 200, "coin_adc_cfg");
      repeat (3) cyc();
      check("coin_state", 32'(state), 2);
      check("coin_retry", 32'(retry_cnt), 1);
      check("coin_ready", 32'(board_ready), 0);
      do_reset();
      mode = 0; ack_en = 0; kick = 1;
      run_until(7, 200, "hold_adc_cfg");
      cyc(); cyc();
      check("hold_req", 32'(adc_cfg_req), 1);
      do_reset();
      check("reset_req_drop", 32'(adc_cfg_req), 0);
      ack_en = 1;
      repeat (5) cyc();
      check("idle_after_reset", 32'(state), 0);
      mode = 1; n_cfg = 0; kick = 1;
      run_until(9, 600, "timeout_fail");
      check("timeout_retry", 32'(retry_cnt), 3);
      check("timeout_error", 32'(error), 1);
      check("timeout_cfg_pulses", n_cfg, 4);
      repeat (3) cyc();
      check("fail_hold", 32'(state), 9);
      mode = 0; kick = 1;
      cyc();
      check("restart_state", 32'(state), 1);
      check("restart_retry", 32'(retry_cnt), 0);
      check("restart_error", 32'(error), 0);
      run_until(8, 200, "loss_ready");
      mode = 5; drop = 1; n = 0;
      while (board_ready && n < 10) begin
         cyc();
         n++;
      end
      check("loss_latency_ok", 32'(n >= 1 && n <= 3), 1);
      check("loss_retry", 32'(retry_cnt), 1);
      check("loss_state", 32'(state), 2);
      drop = 0; mode = 2;
      do_reset();
      for (int s = 0; s < 16; s++) begin
         case ($urandom_range(2, 0))
            0: bias = 2;
            1: bias = 8;
            default: bias = 64;
         endcase
         repeat (250) cyc();
         if ($urandom_range(3, 0) == 0) do_reset();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
